// File: rtl/mc_pack_seq_pkg.sv
// Shared encodings for the read-packing sequencer: bus-width codes, sequencer
// states and the beats-per-word helper.
package mc_pack_seq_pkg;

  localparam logic [1:0] MC_BW_8  = 2'd0;
  localparam logic [1:0] MC_BW_16 = 2'd1;
  localparam logic [1:0] MC_BW_32 = 2'd2;

  typedef enum logic [1:0] {
    MC_PS_IDLE = 2'd0,
    MC_PS_RUN  = 2'd1,
    MC_PS_DONE = 2'd2
  } mc_ps_e;

  function automatic logic [2:0] mc_beats_per_word(input logic [1:0] bw);
    case (bw)
      MC_BW_8:  return 3'd4;
      MC_BW_16: return 3'd2;
      default:  return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mc_pack_tmr.sv
// Beat-ack watchdog for the packing sequencer: reloads on RUN entry and on each
// beat ack, flags expiry combinationally in the RUN cycle where it reaches zero.
module mc_pack_tmr #(
  parameter int TO_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_run,
  input  logic i_ack,
  output logic o_expire
);

  localparam int CW = ($clog2(TO_CYCLES + 1) > 8) ? $clog2(TO_CYCLES + 1) : 8;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load || (i_run && i_ack)) begin
      r_cnt <= CW'(TO_CYCLES);
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expire = i_run & ~i_ack & (r_cnt <= CW'(1));

endmodule

// File: rtl/mc_pack_seq.sv
// Read-packing sequencer: counts memory beats per 32-bit word and drives the pack
// latch enables, dv and in-word byte address. Optional watchdog: MC_PACK_TIMEOUT_EN.
module mc_pack_seq
  import mc_pack_seq_pkg::*;
#(
  parameter int WLEN_W    = 3,
  parameter int TO_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_bus_width,
  input  logic              i_start,
  input  logic [WLEN_W-1:0] i_wlen,
  input  logic              i_beat_ack,
  input  logic              i_abort,
  output logic              o_pack_le0,
  output logic              o_pack_le1,
  output logic              o_pack_le2,
  output logic              o_dv,
  output logic [1:0]        o_adr_lsb,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  mc_ps_e            r_state, w_state_nxt;
  logic [1:0]        r_bcnt;
  logic [1:0]        r_bw;
  logic [WLEN_W-1:0] r_wcnt;
  logic [WLEN_W-1:0] r_wlen;

  logic       w_run, w_start, w_act, w_word_end, w_last_word, w_expire, w_to;
  logic [1:0] w_last_beat;

  assign w_run       = (r_state == MC_PS_RUN);
  assign w_start     = (r_state == MC_PS_IDLE) & i_start & ~i_abort;
  // abort outranks a coincident beat ack, so the partial word is simply dropped
  assign w_act       = w_run & i_beat_ack & ~i_abort;
  assign w_last_beat = 2'(mc_beats_per_word(r_bw) - 3'd1);
  assign w_word_end  = (r_bcnt == w_last_beat);
  assign w_last_word = (r_wcnt == r_wlen);

  assign o_pack_le0 = w_act & (r_bcnt == 2'd0) & (r_bw != MC_BW_32);
  assign o_pack_le1 = w_act & (r_bcnt == 2'd1) & (r_bw == MC_BW_8);
  assign o_pack_le2 = w_act & (r_bcnt == 2'd2) & (r_bw == MC_BW_8);
  assign o_dv       = w_act & w_word_end;
  assign o_busy     = w_run;
  assign o_done     = (r_state == MC_PS_DONE) & ~i_abort;

  always_comb begin
    o_adr_lsb = 2'd0;
    if (w_run) begin
      case (r_bw)
        MC_BW_8:  o_adr_lsb = r_bcnt;
        MC_BW_16: o_adr_lsb = {r_bcnt[0], 1'b0};
        default:  o_adr_lsb = 2'd0;
      endcase
    end
  end

`ifdef MC_PACK_TIMEOUT_EN
  mc_pack_tmr #(
    .TO_CYCLES (TO_CYCLES)
  ) u_tmr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_start),
    .i_run    (w_run),
    .i_ack    (i_beat_ack),
    .o_expire (w_expire)
  );
`else
  // no watchdog: RUN waits for beats indefinitely
  assign w_expire = 1'b0 & (TO_CYCLES > 0);
`endif

  assign w_to  = w_expire & ~i_abort;
  assign o_err = w_to;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= MC_PS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MC_PS_IDLE: if (w_start) w_state_nxt = MC_PS_RUN;
      MC_PS_RUN: begin
        if (i_abort || w_to)          w_state_nxt = MC_PS_IDLE;
        else if (o_dv && w_last_word) w_state_nxt = MC_PS_DONE;
      end
      default: w_state_nxt = MC_PS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bcnt <= 2'd0;
      r_wcnt <= '0;
      r_bw   <= MC_BW_32;
      r_wlen <= '0;
    end else if (w_start) begin
      r_bcnt <= 2'd0;
      r_wcnt <= '0;
      r_bw   <= (i_bus_width == 2'd3) ? MC_BW_32 : i_bus_width;
      r_wlen <= i_wlen;
    end else if (w_act) begin
      r_bcnt <= w_word_end ? 2'd0 : r_bcnt + 2'd1;
      if (w_word_end && !w_last_word) begin
        r_wcnt <= r_wcnt + WLEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mc_pack_seq.sv
// Directed self-checking bench for mc_pack_seq; the watchdog scenario is built
// only when MC_PACK_TIMEOUT_EN is defined.
module tb_mc_pack_seq;

`ifdef MC_PACK_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 255;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] bus_width;
  logic       start;
  logic [2:0] wlen;
  logic       beat_ack;
  logic       abort;
  logic       le0, le1, le2, dv, busy, done, err;
  logic [1:0] adr;
  logic [3:0] strb;

  int n_chk = 0;
  int n_fail = 0;

  assign strb = {le0, le1, le2, dv};

  always #5 clk = ~clk;

  mc_pack_seq #(
    .WLEN_W    (3),
    .TO_CYCLES (TB_TO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_bus_width (bus_width),
    .i_start     (start),
    .i_wlen      (wlen),
    .i_beat_ack  (beat_ack),
    .i_abort     (abort),
    .o_pack_le0  (le0),
    .o_pack_le1  (le1),
    .o_pack_le2  (le2),
    .o_dv        (dv),
    .o_adr_lsb   (adr),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    smp();
    n_chk++;
    if ({strb, adr, busy, done, err} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=%b", {strb, adr, busy, done, err}, 9'd0);
    end
  endtask

  task automatic test_8bit();
    logic [3:0] exp_s [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    cyc(); bus_width = 2'd0; wlen = 3'd0; start = 1'b1;
    smp();
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL 8b_busy_at_start got=%b exp=0", busy); end
    cyc(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat_ack = 1'b1;
      smp();
      n_chk++;
      if ({strb, adr, busy} !== {exp_s[k], 2'(k), 1'b1}) begin
        n_fail++;
        $display("FAIL 8b_beat%0d got strb=%b adr=%0d busy=%b exp strb=%b adr=%0d busy=1",
                 k, strb, adr, busy, exp_s[k], k);
      end
      cyc();
    end
    beat_ack = 1'b0;
    smp();
    n_chk++;
    if ({done, busy, strb} !== {1'b1, 1'b0, 4'b0}) begin
      n_fail++; $display("FAIL 8b_done got done=%b busy=%b strb=%b exp 1 0 0000", done, busy, strb);
    end
    cyc(); smp();
    n_chk++;
    if ({done, busy} !== 2'b00) begin
      n_fail++; $display("FAIL 8b_idle_after got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_16bit_gaps();
    int ndv = 0;
    int beat = 0;
    logic [3:0] exp_s;
    cyc(); bus_width = 2'd1; wlen = 3'd1; start = 1'b1;
    cyc(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      beat_ack = (i % 3 == 0);
      smp();
      if (beat_ack) begin
        exp_s = beat[0] ? 4'b0001 : 4'b1000;
        n_chk++;
        if ({strb, adr} !== {exp_s, beat[0] ? 2'd2 : 2'd0}) begin
          n_fail++;
          $display("FAIL 16b_beat%0d got strb=%b adr=%0d exp strb=%b adr=%0d",
                   beat, strb, adr, exp_s, beat[0] ? 2 : 0);
        end
        beat++;
      end else begin
        n_chk++;
        if ({strb, busy} !== 5'b00001) begin
          n_fail++; $display("FAIL 16b_gap%0d got strb=%b busy=%b exp 0000 1", i, strb, busy);
        end
      end
      if (dv === 1'b1) ndv++;
      cyc();
    end
    beat_ack = 1'b0;
    smp();
    n_chk++;
    if (ndv !== 2 || done !== 1'b1) begin
      n_fail++; $display("FAIL 16b_dv_count got dv=%0d done=%b exp dv=2 done=1", ndv, done);
    end
  endtask

  task automatic test_32bit();
    int ndv = 0;
    int nle = 0;
    cyc(); bus_width = 2'd2; wlen = 3'd7; start = 1'b1;
    cyc(); start = 1'b0; bus_width = 2'd0;
    for (int i = 0; i < 8; i++) begin
      beat_ack = 1'b1;
      smp();
      n_chk++;
      if ({strb, adr, done} !== {4'b0001, 2'd0, 1'b0}) begin
        n_fail++; $display("FAIL 32b_beat%0d got strb=%b adr=%0d done=%b exp 0001 0 0", i, strb, adr, done);
      end
      ndv += int'(dv);
      nle += int'(le0) + int'(le1) + int'(le2);
      cyc();
    end
    beat_ack = 1'b0;
    smp();
    n_chk++;
    if (ndv !== 8 || nle !== 0 || done !== 1'b1) begin
      n_fail++; $display("FAIL 32b_totals got dv=%0d le=%0d done=%b exp dv=8 le=0 done=1", ndv, nle, done);
    end
    bus_width = 2'd2;
  endtask

  task automatic test_abort();
    cyc(); bus_width = 2'd0; wlen = 3'd0; start = 1'b1;
    cyc(); start = 1'b0; beat_ack = 1'b1;
    smp();
    n_chk++;
    if (strb !== 4'b1000) begin n_fail++; $display("FAIL abort_beat0 got strb=%b exp 1000", strb); end
    cyc(); abort = 1'b1;
    smp();
    n_chk++;
    if ({strb, done} !== 5'b0) begin
      n_fail++; $display("FAIL abort_coincident got strb=%b done=%b exp 0000 0", strb, done);
    end
    cyc(); abort = 1'b0; beat_ack = 1'b0;
    smp();
    n_chk++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL abort_idle got busy=%b done=%b exp 0 0", busy, done);
    end
    start = 1'b1; abort = 1'b1;
    cyc(); start = 1'b0; abort = 1'b0;
    smp();
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_idle got busy=%b exp 0", busy); end
    start = 1'b1;
    cyc(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat_ack = 1'b1;
      smp();
      if (k == 3) begin
        n_chk++;
        if (strb !== 4'b0001) begin n_fail++; $display("FAIL restart_dv got strb=%b exp 0001", strb); end
      end
      cyc();
    end
    beat_ack = 1'b0;
    smp();
    n_chk++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL restart_done got done=%b exp 1", done); end
  endtask

  task automatic test_async_reset();
    cyc(); bus_width = 2'd0; wlen = 3'd3; start = 1'b1;
    cyc(); start = 1'b0; beat_ack = 1'b1;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({strb, adr, busy, done} !== 8'd0) begin
      n_fail++; $display("FAIL async_reset got strb=%b adr=%0d busy=%b done=%b exp all 0", strb, adr, busy, done);
    end
    start = 1'b1;
    cyc();
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL start_in_reset got busy=%b exp 0", busy); end
    rst_n = 1'b1; start = 1'b0; beat_ack = 1'b0;
    cyc(); smp();
    n_chk++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL after_reset got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

`ifdef MC_PACK_TIMEOUT_EN
  task automatic test_timeout();
    int nerr = 0;
    cyc(); bus_width = 2'd0; wlen = 3'd0; start = 1'b1;
    cyc(); start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      smp();
      n_chk++;
      if ({err, busy} !== {i == 4, 1'b1}) begin
        n_fail++; $display("FAIL timeout_cyc%0d got err=%b busy=%b exp err=%0d busy=1", i, err, busy, i == 4);
      end
      nerr += int'(err);
      cyc();
    end
    for (int i = 0; i < 6; i++) begin
      smp();
      nerr += int'(err);
      n_chk++;
      if ({busy, done} !== 2'b00) begin
        n_fail++; $display("FAIL timeout_after%0d got busy=%b done=%b exp 0 0", i, busy, done);
      end
      cyc();
    end
    n_chk++;
    if (nerr !== 1) begin n_fail++; $display("FAIL timeout_err_count got=%0d exp=1", nerr); end
  endtask
`else
  task automatic test_no_timeout();
    cyc(); bus_width = 2'd0; wlen = 3'd0; start = 1'b1;
    cyc(); start = 1'b0;
    repeat (300) cyc();
    smp();
    n_chk++;
    if ({busy, err} !== 2'b10) begin
      n_fail++; $display("FAIL no_timeout_wait got busy=%b err=%b exp 1 0", busy, err);
    end
    cyc(); abort = 1'b1;
    cyc(); abort = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; bus_width = 2'd0; start = 1'b0; wlen = 3'd0; beat_ack = 1'b0; abort = 1'b0;
    test_reset();
    cyc(); rst_n = 1'b1;
    test_8bit();
    test_16bit_gaps();
    test_32bit();
    test_abort();
    test_async_reset();
`ifdef MC_PACK_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
